// File: rtl/reg_stor_pkg.sv
// Shared definitions for the register-storage arbiter: state encoding and default sizes.
package reg_stor_pkg;

  localparam int DATA_W   = 8;
  localparam int DEF_N    = 4;
  localparam int DEF_NREG = 4;
  localparam int DEF_AW   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_stor_arbiter_8_if.sv
// Requester-side bus of the arbiter: per-requester request/access lanes plus shared grant/read-back.
interface reg_stor_arbiter_8_if
  import reg_stor_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int AW = DEF_AW
) ();

  logic [N-1:0]        REQ;
  logic [N-1:0]        WE;
  logic [N*AW-1:0]     ADDR;
  logic [N*DATA_W-1:0] WDATA;
  logic [N-1:0]        GNT;
  logic [DATA_W-1:0]   RDATA;
  logic                RVALID;

  modport master (output REQ, WE, ADDR, WDATA, input GNT, RDATA, RVALID);
  modport slave  (input REQ, WE, ADDR, WDATA, output GNT, RDATA, RVALID);

endinterface

// File: rtl/reg_stor_bank_8.sv
// NREG x 8-bit register bank: per-register write enable, sync reset, combinational read mux.
module reg_stor_bank_8
  import reg_stor_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREG-1:0]   en,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;

  // Load each register whose enable is set; others hold.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NREG; i++) begin
      if (en[i]) mem_d[i] = wdata;
    end
  end

  // Storage flops, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < NREG) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/reg_stor_arbiter_8.sv
// Round-robin arbiter sharing the register bank; owner keeps the bank while REQ is held,
// capped at MAX_HOLD accesses when someone else is waiting.
module reg_stor_arbiter_8
  import reg_stor_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = DEF_AW,
  parameter int MAX_HOLD = 8
) (
  input  logic          CLK,
  input  logic          RST,
  reg_stor_arbiter_8_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e        st_q, st_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [IW-1:0]     pick;
  logic              own_req, own_we, others;
  logic [AW-1:0]     own_addr;
  logic [DATA_W-1:0] own_wdata, bank_rdata;
  logic [NREG-1:0]   wen;
  logic [IW-1:0]     own_nxt;

  assign own_req   = bus.REQ[own_q];
  assign own_we    = bus.WE[own_q];
  assign own_addr  = bus.ADDR[int'(own_q)*AW +: AW];
  assign own_wdata = bus.WDATA[int'(own_q)*DATA_W +: DATA_W];
  assign others    = |(bus.REQ & ~gnt_q);
  assign own_nxt   = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    int idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_q) + i) % N;
      if (!found && bus.REQ[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // Arbiter FSM: grant, per-cycle access, hold counting and release.
  always_comb begin
    st_d     = st_q;
    own_d    = own_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wen      = '0;
    case (st_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|bus.REQ) begin
          st_d   = ST_OWN;
          own_d  = pick;
          hold_d = '0;
          gnt_d  = N'(1) << pick;
        end
      end
      ST_OWN: begin
        if (!own_req) begin
          st_d  = ST_IDLE;
          gnt_d = '0;
          rr_d  = own_nxt;
        end else begin
          if (own_we) begin
            if (int'(own_addr) < NREG) wen[own_addr] = 1'b1;
          end else begin
            rdata_d  = bank_rdata;
            rvalid_d = 1'b1;
          end
          // Final capped access still happens; release only if someone else waits.
          if (hold_q == HOLD_LAST && others) begin
            st_d  = ST_IDLE;
            gnt_d = '0;
            rr_d  = own_nxt;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        st_d  = ST_IDLE;
        gnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any ownership.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= ST_IDLE;
      own_q    <= '0;
      rr_q     <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      own_q    <= own_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  reg_stor_bank_8 #(.NREG(NREG), .AW(AW)) u_bank (
    .CLK   (CLK),
    .RST   (RST),
    .en    (wen),
    .wdata (own_wdata),
    .raddr (own_addr),
    .rdata (bank_rdata)
  );

  assign bus.GNT    = gnt_q;
  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;

endmodule

// File: tb/tb_reg_stor_arbiter_8.sv
// Bench for reg_stor_arbiter_8: directed scenarios plus random traffic against a
// transaction-level model (owner id, access count, register array).
module tb_reg_stor_arbiter_8;
  localparam int N = 4, NREG = 4, AW = 2, MH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  reg_stor_arbiter_8_if #(.N(N), .AW(AW)) bus ();

  reg_stor_arbiter_8 #(.N(N), .NREG(NREG), .AW(AW), .MAX_HOLD(MH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*8-1:0]  wdata;
  assign bus.REQ = req;
  assign bus.WE = we;
  assign bus.ADDR = addr;
  assign bus.WDATA = wdata;

  int vecs = 0, errs = 0;

  // model state
  int        m_owner = -1, m_rr = 0, m_cnt = 0;
  logic [7:0] m_regs [NREG];
  logic [N-1:0] m_gnt = '0;
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One edge of the model, from the inputs currently presented.
  task automatic model_step();
    int a, idx;
    if (RST) begin
      m_owner = -1; m_rr = 0; m_cnt = 0; m_rv = 0; m_rd = '0;
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    end else begin
      m_rv = 0;
      if (m_owner < 0) begin
        for (int i = N - 1; i >= 0; i--) begin
          idx = (m_rr + i) % N;
          if (req[idx]) m_owner = idx;
        end
        m_cnt = 0;
      end else if (!req[m_owner]) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        a = int'(addr[m_owner*AW +: AW]);
        if (we[m_owner]) m_regs[a] = wdata[m_owner*8 +: 8];
        else begin m_rd = m_regs[a]; m_rv = 1; end
        m_cnt++;
        if (m_cnt >= MH && (req & ~(N'(1) << m_owner)) != '0) begin
          m_rr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    m_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    chk("gnt", 32'(bus.GNT), 32'(m_gnt));
    chk("rvalid", 32'(bus.RVALID), 32'(m_rv));
    chk("rdata", 32'(bus.RDATA), 32'(m_rd));
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0;
    // 1: reset state and zeroed registers
    do_reset();
    chk("rst_gnt", 32'(bus.GNT), 0);
    chk("rst_rvalid", 32'(bus.RVALID), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    req = 4'b0001; tick();
    for (int r = 0; r < NREG; r++) begin
      addr[0 +: AW] = AW'(r); tick();
      chk("rst_reg_rd", {31'd0, bus.RVALID} << 8 | 32'(bus.RDATA), 32'h100);
    end
    req = '0; tick(); tick();

    // 2: write 0xA5 to reg 2 then read it back
    req = 4'b0001; we = 4'b0001; addr[0 +: AW] = 2'd2; wdata[0 +: 8] = 8'hA5;
    tick(); chk("t2_gnt", 32'(bus.GNT), 32'h1);
    tick();
    we = '0; tick();
    chk("t2_rdata", 32'(bus.RDATA), 32'hA5);
    chk("t2_rvalid", 32'(bus.RVALID), 1);
    req = '0; tick(); tick();

    // 3: all requesting: 8 accesses each, one idle cycle between owners
    do_reset();
    req = 4'b1111; we = '0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      chk("t3_seq", 32'(bus.GNT), ((t - 1) % 9 < 8) ? (32'h1 << (((t - 1) / 9) % 4)) : 0);
    end

    // 4: sole requester is never forced off
    do_reset();
    req = 4'b0100;
    for (int t = 0; t < 21; t++) begin
      tick();
      chk("t4_hold", 32'(bus.GNT), 32'h4);
    end

    // 5: reset mid-ownership discards the write in flight
    req = '0; do_reset();
    req = 4'b0010; we = 4'b0010; addr[AW +: AW] = 2'd3; wdata[8 +: 8] = 8'h77;
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    chk("t5_gnt", 32'(bus.GNT), 0);
    we = '0; tick(); tick();
    chk("t5_noWrite", 32'(bus.RDATA), 0);

    // 6: owner 2 drops with 0 and 3 pending -> idle, then 3
    req = '0; do_reset();
    req = 4'b0100; tick(); tick();
    req = 4'b1101; tick(); tick();
    req = 4'b1001; tick();
    chk("t6_idle", 32'(bus.GNT), 0);
    tick();
    chk("t6_next", 32'(bus.GNT), 32'h8);

    // random traffic
    req = '0; do_reset();
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      we = N'($urandom);
      addr = (N*AW)'($urandom);
      wdata = {$urandom};
      tick();
    end
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
